// File: rtl/mips_pkg.sv
// mips_pkg: fetch state encoding, opcode field bounds and opcode constants shared by fetch and control decode.
package mips_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2
    } fetch_state_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    function automatic logic [5:0] op_of(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc4} holding slot for a word fetched while decode is stalled.
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc4,
    output logic              full,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (flush) begin
            full  <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc4   <= load_pc4;
        end else if (unload) begin
            full  <= 1'b0;
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS fetch stage with IF/ID register and skid buffer; IF_FETCH_PERF_EN adds fetch/squash counters.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [5:0]        id_op,
    output logic [ADDR_W-1:0] id_pc4
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed
`endif
);
    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d, pend_pc, pend_pc_d, pc_inc, id_pc4_d, skid_pc4;
    logic              drop, drop_d, id_valid_d, skid_load, skid_unload, skid_full;
    logic [31:0]       id_instr_d, skid_instr;

    assign pc_inc    = pc + ADDR_W'(4);
    assign imem_req  = state == S_REQ;
    assign imem_addr = pc;
    assign id_op     = op_of(id_instr);

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .flush      (redirect),
        .load_instr (imem_rdata),
        .load_pc4   (pc_inc),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc4        (skid_pc4)
    );

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        pend_pc_d   = pend_pc;
        drop_d      = drop;
        id_valid_d  = id_valid & stall;
        id_instr_d  = (id_valid & !stall) ? NOP_INSTR : id_instr;
        id_pc4_d    = id_pc4;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        case (state)
            S_IDLE: begin
                state_d = S_REQ;
                pc_d    = redirect ? redirect_pc : pc;
            end
            S_REQ: begin
                if (imem_ack) begin
                    drop_d = 1'b0;
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else if (drop) begin
                        pc_d = pend_pc;
                    end else begin
                        pc_d = pc_inc;
                        if (!id_valid || !stall) begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem_rdata;
                            id_pc4_d   = pc_inc;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_FULL;
                        end
                    end
                end else if (redirect) begin
                    // address stays put until the outstanding ack; that word is dropped
                    pend_pc_d = redirect_pc;
                    drop_d    = 1'b1;
                end
            end
            S_FULL: begin
                if (!stall) begin
                    id_valid_d  = 1'b1;
                    id_instr_d  = skid_instr;
                    id_pc4_d    = skid_pc4;
                    skid_unload = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (redirect) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            skid_load  = 1'b0;
            if (state == S_FULL) begin
                state_d     = S_REQ;
                pc_d        = redirect_pc;
                drop_d      = 1'b0;
                skid_unload = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            pend_pc  <= '0;
            drop     <= 1'b0;
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc4   <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            pend_pc  <= pend_pc_d;
            drop     <= drop_d;
            id_valid <= id_valid_d;
            id_instr <= id_instr_d;
            id_pc4   <= id_pc4_d;
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic accept, discard;
    assign accept  = imem_req & imem_ack & !redirect & !drop;
    assign discard = imem_req & imem_ack & (redirect | drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            perf_fetched  <= perf_fetched + 32'(accept);
            perf_squashed <= perf_squashed + 32'(discard) + 32'(redirect & id_valid) + 32'(redirect & skid_full);
        end
    end
`endif
endmodule
